// File: rtl/ping_pong_checker_if.sv
// Sample stream and status bundle between a ping-pong counter's consumer side
// and the sequence checker. The master drives samples and bounds; the slave
// (the checker) returns lock and error status.
interface ping_pong_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             valid;
  logic [WIDTH-1:0] value;
  logic             direction;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] min;
  logic             clear;

  logic             locked;
  logic [WIDTH-1:0] expect_value;
  logic             err_pulse;
  logic             error;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bounce_count;

  modport master (
    output valid, value, direction, max, min, clear,
    input  locked, expect_value, err_pulse, error, err_count, bounce_count
  );

  modport slave (
    input  valid, value, direction, max, min, clear,
    output locked, expect_value, err_pulse, error, err_count, bounce_count
  );
endinterface

// File: rtl/ping_pong_checker.sv
// Sequence checker for a ping-pong counter's out/direction stream.
// Predicts the single legal successor of each sample, counts direction
// reversals and illegal steps, and always resyncs to the received sample so
// one glitch costs one error.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no reference sample yet; next valid sample is acquired
// S_TRACK | prev/prev_dir hold the last sample; each sample is checked
module ping_pong_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ping_pong_checker_if.slave    bus
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] prev_q;
  logic             prev_dir_q;
  logic [WIDTH-1:0] expect_q;
  logic             err_pulse_q;
  logic             error_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] bounce_count_q;

  logic             bounds_ok;
  logic             out_of_range;
  logic [WIDTH-1:0] up_step;
  logic [WIDTH-1:0] dn_step;
  logic [WIDTH-1:0] exp_value;
  logic             tracking;
  logic             step_bad;
  logic             sample_bad;
  logic             bounce;
  logic             accept;
  logic [WIDTH-1:0] next_expect;

  // Legal-successor prediction and sample classification.
  // The range check also applies to the acquiring sample; with illegal bounds
  // only the lower bound is enforced, matching the tracking rule.
  always_comb begin
    bounds_ok    = (bus.max > bus.min);
    out_of_range = (bus.value < bus.min) || (bounds_ok && (bus.value > bus.max));
    up_step      = (prev_q < bus.max) ? (prev_q + ONE_W) : prev_q;
    dn_step      = (prev_q > bus.min) ? (prev_q - ONE_W) : prev_q;
    if (!bounds_ok) begin
      exp_value = prev_q;
    end else if (bus.direction) begin
      exp_value = up_step;
    end else begin
      exp_value = dn_step;
    end
    tracking    = (state_q == S_TRACK);
    step_bad    = tracking && (bus.value != exp_value);
    sample_bad  = out_of_range || step_bad;
    bounce      = tracking && (bus.direction != prev_dir_q);
    accept      = bus.valid && !bus.clear;
    // Up-step of the sample that becomes the new prev, clamped at max.
    next_expect = (bus.value < bus.max) ? (bus.value + ONE_W) : bus.value;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear always drops back to IDLE; any accepted sample locks.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else if (bus.valid) begin
      state_d = S_TRACK;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.locked = (state_q == S_TRACK);
  end

  // Reference sample and prediction; reloaded from every accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_dir_q <= 1'b1;
      expect_q   <= '0;
    end else if (accept) begin
      prev_q     <= bus.value;
      prev_dir_q <= bus.direction;
      expect_q   <= next_expect;
    end
  end

  // Error pulse, sticky flag and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else if (bus.clear) begin
      err_pulse_q <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= bus.valid && sample_bad;
      if (bus.valid && sample_bad) begin
        error_q <= 1'b1;
        if (err_count_q != CNT_SAT) begin
          err_count_q <= err_count_q + ONE_C;
        end
      end
    end
  end

  // Direction reversal counter; wraps, counts legal and illegal samples alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bounce_count_q <= '0;
    end else if (bus.clear) begin
      bounce_count_q <= '0;
    end else if (bus.valid && bounce) begin
      bounce_count_q <= bounce_count_q + ONE_C;
    end
  end

  // Registered status onto the interface.
  always_comb begin
    bus.expect_value = expect_q;
    bus.err_pulse    = err_pulse_q;
    bus.error        = error_q;
    bus.err_count    = err_count_q;
    bus.bounce_count = bounce_count_q;
  end

endmodule

// File: tb/tb_ping_pong_checker.sv
// Bench for ping_pong_checker: directed scenarios followed by a randomized
// ping-pong stream, all compared against a behavioural model of the checker.
module tb_ping_pong_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ping_pong_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ping_pong_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  bit m_locked;
  int m_prev;
  int m_dir;
  int m_exp;
  bit m_pulse;
  bit m_err;
  int m_errc;
  int m_bnc;

  task automatic model_reset();
    m_locked = 0; m_prev = 0; m_dir = 1; m_exp = 0;
    m_pulse = 0; m_err = 0; m_errc = 0; m_bnc = 0;
  endtask

  // Legal successor computed from the stream rules with plain integers.
  function automatic int successor(int prev, int dir, int mx, int mn);
    if (mx <= mn) return prev;
    if (dir == 1) return (prev < mx) ? prev + 1 : prev;
    return (prev > mn) ? prev - 1 : prev;
  endfunction

  task automatic model_step(bit vld, int v, int d, int mx, int mn, bit clr);
    bit bad;
    if (clr) begin
      m_locked = 0; m_pulse = 0; m_err = 0; m_errc = 0; m_bnc = 0;
    end else if (!vld) begin
      m_pulse = 0;
    end else begin
      bad = (v < mn) || ((mx > mn) && (v > mx));
      if (m_locked) begin
        if (v != successor(m_prev, d, mx, mn)) bad = 1;
        if (d != m_dir) m_bnc = (m_bnc + 1) % (CMAX + 1);
      end
      m_pulse = bad;
      if (bad) begin
        m_err = 1;
        if (m_errc < CMAX) m_errc++;
      end
      m_locked = 1;
      m_prev = v;
      m_dir = d;
      m_exp = (v < mx) ? v + 1 : v;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    check({tag, ".locked"},       {31'd0, bus.locked},            m_locked);
    check({tag, ".expect_value"}, {28'd0, bus.expect_value},      m_exp);
    check({tag, ".err_pulse"},    {31'd0, bus.err_pulse},         m_pulse);
    check({tag, ".error"},        {31'd0, bus.error},             m_err);
    check({tag, ".err_count"},    {24'd0, bus.err_count},         m_errc);
    check({tag, ".bounce_count"}, {24'd0, bus.bounce_count},      m_bnc);
  endtask

  task automatic step(string tag, bit vld, int v, int d, int mx, int mn, bit clr);
    @(negedge clk);
    bus.valid     = vld;
    bus.value     = v[WIDTH-1:0];
    bus.direction = d[0];
    bus.max       = mx[WIDTH-1:0];
    bus.min       = mn[WIDTH-1:0];
    bus.clear     = clr;
    @(posedge clk);
    model_step(vld, v, d, mx, mn, clr);
    #1;
    check_all(tag);
  endtask

  int mx, mn, tdir, v;
  bit vld, clr;

  initial begin
    bus.valid = 0; bus.value = '0; bus.direction = 0;
    bus.max = '0; bus.min = '0; bus.clear = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal up count, then turnaround at max.
    step("up2", 1, 2, 1, 5, 2, 0);
    check("up2.locked_const", {31'd0, bus.locked}, 1);
    step("up3", 1, 3, 1, 5, 2, 0);
    step("up4", 1, 4, 1, 5, 2, 0);
    step("up5", 1, 5, 1, 5, 2, 0);
    check("up5.expect_const", {28'd0, bus.expect_value}, 5);
    step("dn4", 1, 4, 0, 5, 2, 0);
    step("dn3", 1, 3, 0, 5, 2, 0);
    check("turn.bounce_const", {24'd0, bus.bounce_count}, 1);
    step("idle", 0, 9, 1, 5, 2, 0);

    // Flip at the bound with a hold: acquire (5,0) then (5,1).
    step("clr1", 1, 5, 0, 5, 2, 1);
    step("acq50", 1, 5, 0, 5, 2, 0);
    step("hold51", 1, 5, 1, 5, 2, 0);
    check("hold.error_const", {31'd0, bus.error}, 0);

    // Skipped value then resync.
    step("clr2", 0, 0, 1, 5, 2, 1);
    step("acq31", 1, 3, 1, 5, 2, 0);
    step("skip51", 1, 5, 1, 5, 2, 0);
    check("skip.pulse_const", {31'd0, bus.err_pulse}, 1);
    step("resync40", 1, 4, 0, 5, 2, 0);
    check("resync.errc_const", {24'd0, bus.err_count}, 1);
    step("gap", 0, 0, 0, 5, 2, 0);

    // Illegal bounds max == min == 3.
    step("clr3", 0, 0, 1, 3, 3, 1);
    step("ib31", 1, 3, 1, 3, 3, 0);
    step("ib30", 1, 3, 0, 3, 3, 0);
    step("ib41", 1, 4, 1, 3, 3, 0);

    // Saturate the error counter: value below min every cycle.
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.valid = 1; bus.value = '0; bus.direction = 1;
      bus.max = 4'd5; bus.min = 4'd2; bus.clear = 0;
      @(posedge clk);
      model_step(1, 0, 1, 5, 2, 0);
    end
    #1;
    check_all("sat");
    check("sat.errc_const", {24'd0, bus.err_count}, CMAX);

    // Clear together with valid.
    step("clr_valid", 1, 3, 1, 5, 2, 1);
    check("clr_valid.locked_const", {31'd0, bus.locked}, 0);

    // Randomized ping-pong stream with occasional glitches, clears and bound changes.
    mx = 9; mn = 2; tdir = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        mn = $urandom_range(0, 8);
        mx = $urandom_range(0, 15);
      end
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 60) == 0);
      if (tdir == 1 && m_prev >= mx) tdir = 0;
      else if (tdir == 0 && m_prev <= mn) tdir = 1;
      if ($urandom_range(0, 15) == 0) tdir = 1 - tdir;
      if (!m_locked) v = $urandom_range(mn, (mx > mn) ? mx : 15);
      else v = successor(m_prev, tdir, mx, mn);
      if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 15);
      step("rand", vld, v, tdir, mx, mn, clr);
    end

    // Asynchronous reset between edges, then reacquire.
    step("pre_rst", 1, 4, 1, 9, 2, 0);
    @(negedge clk);
    bus.valid = 0; bus.clear = 0;
    @(posedge clk);
    model_step(0, 0, 0, 9, 2, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("reacq", 1, 7, 0, 9, 2, 0);
    step("reacq_next", 1, 6, 0, 9, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
